// File: rtl/sseg_pkg.sv
// sseg_pkg: constants and the hex-to-segment decode shared by the
// seven-segment scan controller and its decoder.
//   DIGIT_W      - bits per displayed hex digit
//   SSEG_BLANK   - segment pattern with every segment (and dp) dark
//   hex_to_sseg  - nibble to active-low segments, [6:0] = a..g
package sseg_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex nibble to active-low a..g segments.
//   nib [3:0] - hex value to show
//   seg [6:0] - active-low segments, [6] = a ... [0] = g
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure table lookup through the shared decode function.
  always_comb begin
    seg = hex_to_sseg(nib);
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed seven-segment display scanner.
// Data is captured into shadow registers on load and moved into the
// display registers only at the frame wrap, so a frame never tears.
// Each digit owns a slot of 2^PRESCALE_W clocks; within a slot the
// digit is lit while the top four slot-counter bits are <= brightness.
//   clk, reset   - clock, synchronous active-high reset
//   load         - capture digits_in / dp_in / blink_mask into shadow
//   digits_in    - hex nibbles, digit i at [4i+3:4i]
//   dp_in        - decimal points, 1 = lit
//   blink_mask   - 1 = digit blinks with the blink counter MSB
//   blank_lz     - leading-zero blanking enable (live)
//   brightness   - duty level 0..15 (live)
//   an           - active-low digit enables (registered)
//   sseg         - active-low segments {dp, a..g} (registered)
//   frame_done   - one-cycle pulse in the frame-wrap cycle
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE_W = 16,
  parameter int BLINK_W    = 25
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blank_lz,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [7:0]                    sseg,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESCALE_W-1:0] SLOT_MAX = {PRESCALE_W{1'b1}};
  // One cycle before the slot wrap, used to register frame_done early.
  localparam logic [PRESCALE_W-1:0] SLOT_PRE = {{(PRESCALE_W-1){1'b1}}, 1'b0};

  // Scan counters
  logic [PRESCALE_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;

  // Shadow and display copies of the loaded data
  logic [DIGIT_W*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]         sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]         sh_blink_q, sh_blink_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]         disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]         disp_blink_q, disp_blink_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic                  frame_done_q, frame_done_d;

  // Combinational helpers
  logic                  slot_wrap_s;
  logic                  frame_wrap_s;
  logic [NUM_DIGITS-1:0] nib_zero_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blink_s;
  logic                  lz_blank_s;
  logic                  blink_off_s;
  logic                  duty_ok_s;
  logic                  lit_s;
  logic [6:0]            seg_s;

  sseg_hex_decode u_dec (
    .nib (cur_nib_s),
    .seg (seg_s)
  );

  // Slot/digit/blink counters and the frame-wrap detection.
  always_comb begin
    slot_wrap_s  = (slot_q == SLOT_MAX);
    frame_wrap_s = slot_wrap_s && (idx_q == LAST_IDX);
    slot_d       = slot_q + PRESCALE_W'(1);
    blink_d      = blink_q + BLINK_W'(1);
    if (frame_wrap_s) begin
      idx_d = '0;
    end else if (slot_wrap_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    // Registered one cycle ahead so the pulse lands in the wrap cycle itself.
    frame_done_d = (slot_q == SLOT_PRE) && (idx_q == LAST_IDX);
  end

  // Shadow capture on load; display takes the old shadow value at frame wrap.
  always_comb begin
    if (load) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_blink_d  = blink_mask;
    end else begin
      sh_digits_d = sh_digits_q;
      sh_dp_d     = sh_dp_q;
      sh_blink_d  = sh_blink_q;
    end
    if (frame_wrap_s) begin
      disp_digits_d = sh_digits_q;
      disp_dp_d     = sh_dp_q;
      disp_blink_d  = sh_blink_q;
    end else begin
      disp_digits_d = disp_digits_q;
      disp_dp_d     = disp_dp_q;
      disp_blink_d  = disp_blink_q;
    end
  end

  // Lit decision for the digit currently being scanned.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_zero_s[i] = (disp_digits_q[i*DIGIT_W +: DIGIT_W] == 4'h0);
    end
    cur_nib_s   = disp_digits_q[DIGIT_W*idx_q +: DIGIT_W];
    cur_dp_s    = disp_dp_q[idx_q];
    cur_blink_s = disp_blink_q[idx_q];
    // Blank when every nibble at this index and above is zero; digit 0 never.
    lz_blank_s  = blank_lz && (idx_q != '0) && ((~nib_zero_s >> idx_q) == '0);
    blink_off_s = cur_blink_s && blink_q[BLINK_W-1];
    duty_ok_s   = (slot_q[PRESCALE_W-1 -: 4] <= brightness);
    lit_s       = !lz_blank_s && !blink_off_s && duty_ok_s;
  end

  // Output pattern for the next cycle: one anode low when lit, all dark otherwise.
  always_comb begin
    if (lit_s) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
      sseg_d = {~cur_dp_s, seg_s};
    end else begin
      an_d   = {NUM_DIGITS{1'b1}};
      sseg_d = SSEG_BLANK;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= '0;
      idx_q         <= '0;
      blink_q       <= '0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_blink_q    <= '0;
      disp_digits_q <= '0;
      disp_dp_q     <= '0;
      disp_blink_q  <= '0;
      an_q          <= {NUM_DIGITS{1'b1}};
      sseg_q        <= SSEG_BLANK;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      blink_q       <= blink_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blink_q    <= sh_blink_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_blink_q  <= disp_blink_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: self-checking bench for sseg_scan_ctrl with
// NUM_DIGITS=4, PRESCALE_W=4, BLINK_W=6. A cycle model queues the
// expected an/sseg for every clock and they are compared one clock
// later; directed windows of 64 clocks tally how long each digit is
// lit and what it shows.
module tb_sseg_scan_ctrl;

  localparam int ND = 4;
  localparam int PW = 4;
  localparam int BW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int total  = 0;
  int passed = 0;

  // Reference model state
  int          m_slot, m_digit, m_blink;
  logic [15:0] m_sh_dig, m_ds_dig;
  logic [3:0]  m_sh_dp, m_ds_dp, m_sh_bm, m_ds_bm;
  logic [11:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  sseg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE_W(PW), .BLINK_W(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: queue the model's expected output, advance model, compare.
  task automatic tick();
    logic [3:0]  e_an;
    logic [7:0]  e_sg;
    logic [3:0]  nib;
    logic [15:0] upper;
    logic        lz, blink_off, lit;
    logic [11:0] e;
    if (reset) begin
      e_an = 4'hF;
      e_sg = 8'hFF;
    end else begin
      upper     = m_ds_dig >> (4 * m_digit);
      nib       = upper[3:0];
      lz        = blank_lz && (m_digit != 0) && (upper == 16'h0000);
      blink_off = m_ds_bm[m_digit] && (((m_blink >> (BW - 1)) & 1) == 1);
      lit       = !lz && !blink_off && (m_slot <= int'(brightness));
      if (lit) begin
        e_an = 4'b0001 << m_digit;
        e_an = ~e_an;
        e_sg = {~m_ds_dp[m_digit], seg_tab[nib]};
      end else begin
        e_an = 4'hF;
        e_sg = 8'hFF;
      end
    end
    exp_q.push_back({e_an, e_sg});
    if (reset) begin
      m_slot = 0; m_digit = 0; m_blink = 0;
      m_sh_dig = 16'h0; m_sh_dp = 4'h0; m_sh_bm = 4'h0;
      m_ds_dig = 16'h0; m_ds_dp = 4'h0; m_ds_bm = 4'h0;
    end else begin
      if (m_slot == 15 && m_digit == 3) begin
        m_ds_dig = m_sh_dig; m_ds_dp = m_sh_dp; m_ds_bm = m_sh_bm;
      end
      if (load) begin
        m_sh_dig = digits_in; m_sh_dp = dp_in; m_sh_bm = blink_mask;
      end
      if (m_slot == 15) begin
        m_slot  = 0;
        m_digit = (m_digit + 1) % ND;
      end else begin
        m_slot = m_slot + 1;
      end
      m_blink = (m_blink + 1) % 64;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("an", {28'h0, an}, {28'h0, e[11:8]});
    chk("sseg", {24'h0, sseg}, {24'h0, e[7:0]});
    chk("frame_done", {31'h0, frame_done}, {31'h0, (m_slot == 15 && m_digit == 3)});
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("frame_wait", {31'h0, frame_done}, 32'd1);
  endtask

  // 64 clocks: count clocks each digit is lit and check what it shows.
  task automatic window(input string tag, input int c0, input int c1, input int c2, input int c3,
                        input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
    int         cnt[4];
    int         want[4];
    logic [7:0] sg[4];
    logic [3:0] pat;
    cnt  = '{0, 0, 0, 0};
    want = '{c0, c1, c2, c3};
    sg   = '{s0, s1, s2, s3};
    repeat (64) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        pat = 4'b0001 << d;
        pat = ~pat;
        if (an === pat) begin
          cnt[d]++;
          chk({tag, "_seg"}, {24'h0, sseg}, {24'h0, sg[d]});
        end
      end
    end
    for (int d = 0; d < 4; d++) chk({tag, "_cnt"}, cnt[d], want[d]);
  endtask

  task automatic do_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] bm);
    digits_in  = dig;
    dp_in      = dp;
    blink_mask = bm;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
    blink_mask = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
    m_slot = 0; m_digit = 0; m_blink = 0;
    m_sh_dig = 16'h0; m_sh_dp = 4'h0; m_sh_bm = 4'h0;
    m_ds_dig = 16'h0; m_ds_dp = 4'h0; m_ds_bm = 4'h0;

    // Reset state, with load asserted to confirm it is ignored
    load = 1'b1; digits_in = 16'hFFFF;
    repeat (3) tick();
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_sseg", {24'h0, sseg}, 32'hFF);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);
    load = 1'b0;
    reset = 1'b0;

    // Basic scan of 12AF at full brightness
    do_load(16'h12AF, 4'h0, 4'h0);
    wait_frame();
    tick();
    window("scan", 16, 16, 16, 16, 8'hB8, 8'h88, 8'h92, 8'hCF);

    // Quarter duty
    brightness = 4'd3;
    window("duty3", 4, 4, 4, 4, 8'hB8, 8'h88, 8'h92, 8'hCF);
    brightness = 4'd0;
    window("duty0", 1, 1, 1, 1, 8'hB8, 8'h88, 8'h92, 8'hCF);
    brightness = 4'hF;

    // Leading-zero blanking also kills the dp of blanked digits
    blank_lz = 1'b1;
    do_load(16'h0050, 4'hF, 4'h0);
    wait_frame();
    tick();
    window("lz0050", 16, 16, 0, 0, 8'h01, 8'h24, 8'hFF, 8'hFF);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_frame();
    tick();
    window("lz0000", 16, 0, 0, 0, 8'h81, 8'hFF, 8'hFF, 8'hFF);
    blank_lz = 1'b0;

    // Blink: digit2 falls in the MSB=1 half, digit1 in the MSB=0 half
    do_load(16'h12AF, 4'h0, 4'b0100);
    wait_frame();
    tick();
    window("blink2", 16, 16, 0, 16, 8'hB8, 8'h88, 8'h92, 8'hCF);
    do_load(16'h12AF, 4'h0, 4'b0010);
    wait_frame();
    tick();
    window("blink1", 16, 16, 16, 16, 8'hB8, 8'h88, 8'h92, 8'hCF);

    // Load in the frame-wrap cycle: old value holds for one more frame
    wait_frame();
    digits_in = 16'h3333; dp_in = 4'h0; blink_mask = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    window("wrapold", 16, 16, 16, 16, 8'hB8, 8'h88, 8'h92, 8'hCF);
    window("wrapnew", 16, 16, 16, 16, 8'h86, 8'h86, 8'h86, 8'h86);

    // Reset mid-slot: dark immediately, then restart at digit 0 slot 0
    repeat (21) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_an", {28'h0, an}, 32'hF);
    chk("mid_rst_sseg", {24'h0, sseg}, 32'hFF);
    reset = 1'b0;
    tick();
    chk("restart_an", {28'h0, an}, 32'hE);
    chk("restart_sseg", {24'h0, sseg}, 32'h81);
    repeat (70) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the slot counter; one digit slot lasts 2^PRESCALE_W clocks; minimum 4.
REQ-003 SHALL have parameter BLINK_W, default 25: width of the free-running blink counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port load, input, 1 bit: capture strobe for digits_in, dp_in and blink_mask.
REQ-007 SHALL have port digits_in, input, 4*NUM_DIGITS bits: hex nibbles, with digit i at [4i+3:4i].
REQ-008 SHALL have port dp_in, input, NUM_DIGITS bits: decimal points, 1 = lit.
REQ-009 SHALL have port blink_mask, input, NUM_DIGITS bits: 1 = digit blinks.
REQ-010 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled live.
REQ-011 SHALL have port brightness, input, 4 bits: duty level, sampled live.
REQ-012 SHALL have port an, output, NUM_DIGITS bits: digit enables, active-low.
REQ-013 SHALL have port sseg, output, 8 bits: active-low segments, with [6:0] = a..g and [7] = dp.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-015 SHALL capture digits_in, dp_in and blink_mask into shadow registers on any clock edge where load=1.
REQ-016 SHALL copy the shadow registers into display registers only in the frame-wrap cycle, so no frame tears.
REQ-017 SHALL, when load coincides with the frame-wrap cycle, give display registers the pre-load shadow value; the new data appears one frame later.
REQ-018 SHALL increment the slot counter every clock and wrap it to 0.
REQ-019 SHALL advance the digit index by one when the slot counter wraps, going 0..NUM_DIGITS-1 and then back to 0.
REQ-020 SHALL treat the frame wrap as the cycle the digit index goes from NUM_DIGITS-1 to 0; frame_done SHALL be 1 in exactly that cycle.
REQ-021 SHALL compute a digit as lit when: not LZ-blanked, AND not (blink_mask[i] AND blink counter MSB = 1), AND slot counter[PRESCALE_W-1:PRESCALE_W-4] <= brightness.
REQ-022 SHALL produce duties as follows: brightness 15 = 100%; brightness 0 = 1/16 of each slot.
REQ-023 SHALL, with blank_lz=1, blank digit i when all display nibbles at indices >= i are 0.
REQ-024 SHALL never LZ-blank digit 0.
REQ-025 SHALL make LZ blanking suppress that digit's dp as well.
REQ-026 SHALL, for a lit digit, drive an = ~(1<<index) and sseg = {~dp, decode(nibble)}.
REQ-027 SHALL, for an unlit digit, drive an all-ones and sseg = 8'hFF.
REQ-028 SHALL use this decode for 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-029 SHALL register an and sseg, giving 1-cycle latency from counter state to outputs.
REQ-030 SHALL never assert more than one an bit low in any cycle.

Reset
REQ-031 SHALL, while reset=1 at a clock edge, clear the slot counter, digit index, blink counter, shadow registers and display registers to 0.
REQ-032 SHALL, while reset=1 at a clock edge, drive an to all-ones, sseg to 8'hFF and frame_done to 0.
REQ-033 SHALL ignore load while reset=1.
REQ-034 SHALL, on reset mid-frame, abort the scan and restart it at digit 0, slot 0.

Structure
REQ-035 SHALL place the hex-to-segment decode function, SSEG_BLANK = 8'hFF and the digit-width constant 4 in the shared package sseg_pkg.
REQ-036 SHALL implement the combinational decode as the sub-module sseg_hex_decode (4-bit in, 7-bit out), instantiated once.

Verification
Bench parameters: NUM_DIGITS=4, PRESCALE_W=4, BLINK_W=6.
REQ-037 SHALL cover: reset, then load digits 16'h12AF with brightness=15 -> after the next frame_done, slots show digit0 sseg=8'hB8, digit1 8'h88, digit2 8'h92, digit3 8'hCF; each an pattern is held 16 clocks.
REQ-038 SHALL cover: digits 16'h0050, blank_lz=1 -> digit3 and digit2 have an=4'hF and sseg=8'hFF; digits 1 and 0 are lit (5, then 0).
REQ-039 SHALL cover: digits 16'h0000, blank_lz=1 -> only digit0 is lit, showing 8'h81.
REQ-040 SHALL cover: brightness=3 -> each digit is lit for exactly 4 of its 16 slot clocks.
REQ-041 SHALL cover: blink_mask=4'b0010 -> digit1 is dark while blink MSB=1 (32-clock half-periods) and other digits are unaffected.
REQ-042 SHALL cover: load in the frame-wrap cycle -> the old value is shown for one more frame; also reset asserted mid-slot -> the next cycle has an=4'hF and sseg=8'hFF, and the scan restarts at digit 0.
